// File: rtl/svc_rv_run_ctrl_pkg.sv
// Shared types for the RISC-V run controller: the run-state encoding.
package svc_rv_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } run_state_e;

endpackage

// File: rtl/svc_rv_run_ctrl.sv
// Run controller: holds the CPU in reset, releases it for one run, and stops on ebreak or start.
// Optional watchdog compiled in with `define SVC_RV_RUN_CTRL_WDT_EN.
module svc_rv_run_ctrl
    import svc_rv_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 32,
    parameter int AUTO_START     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ebreak,
    output logic             cpu_rst_n,
    output logic             running,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycles
);

    localparam int                HOLD_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
    localparam run_state_e        RESET_STATE = (AUTO_START != 0) ? ST_HOLD : ST_IDLE;

    run_state_e        state;
    run_state_e        state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              wdt_fire;

`ifdef SVC_RV_RUN_CTRL_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    assign wdt_fire = (cycles == WDT_LAST);
`else
    assign wdt_fire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; start has priority over ebreak, ebreak over the watchdog.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start) state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (!start && hold_cnt == HOLD_LAST) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (start)         state_nx = ST_HOLD;
                else if (ebreak)   state_nx = ST_DONE;
                else if (wdt_fire) state_nx = ST_FAULT;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Status outputs are pure state decodes; the sticky flags live in the state itself.
    always_comb begin
        running = (state == ST_RUN);
        done    = (state == ST_DONE);
`ifdef SVC_RV_RUN_CTRL_WDT_EN
        timed_out = (state == ST_FAULT);
`else
        timed_out = 1'b0;
`endif
    end

    // Hold counter, run-cycle counter and the CPU reset flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
            hold_cnt  <= '0;
            cycles    <= '0;
            cpu_rst_n <= 1'b0;
        end else begin
            if (state == ST_HOLD && !start) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end

            if (start) begin
                cycles <= '0;
            end else if (state == ST_RUN && cycles != '1) begin
                cycles <= cycles + 1'b1;
            end

            // NOTE: cpu_rst_n comes straight from a flop so decode glitches never reach the CPU.
            cpu_rst_n <= (state_nx == ST_RUN);
        end
    end

endmodule

// File: tb/tb_svc_rv_run_ctrl.sv
// Directed self-checking bench for svc_rv_run_ctrl (watchdog expectations follow SVC_RV_RUN_CTRL_WDT_EN).
module tb_svc_rv_run_ctrl;

    localparam int CNT_W = 16;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start  = 1'b0;
    logic ebreak = 1'b0;
    logic start_ns  = 1'b0;
    logic ebreak_ns = 1'b1;
    logic start_sat  = 1'b0;
    logic ebreak_sat = 1'b0;

    logic             cpu_rst_n, running, done, timed_out;
    logic [CNT_W-1:0] cycles;
    logic             cpu_rst_n_ns, running_ns, done_ns, timed_out_ns;
    logic [CNT_W-1:0] cycles_ns;
    logic             cpu_rst_n_sat, running_sat, done_sat, timed_out_sat;
    logic [3:0]       cycles_sat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    svc_rv_run_ctrl #(
        .RST_CYCLES(4), .TIMEOUT_CYCLES(100), .CNT_W(CNT_W), .AUTO_START(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ebreak(ebreak),
        .cpu_rst_n(cpu_rst_n), .running(running), .done(done),
        .timed_out(timed_out), .cycles(cycles)
    );

    svc_rv_run_ctrl #(
        .RST_CYCLES(4), .TIMEOUT_CYCLES(100), .CNT_W(CNT_W), .AUTO_START(0)
    ) dut_ns (
        .clk(clk), .rst_n(rst_n), .start(start_ns), .ebreak(ebreak_ns),
        .cpu_rst_n(cpu_rst_n_ns), .running(running_ns), .done(done_ns),
        .timed_out(timed_out_ns), .cycles(cycles_ns)
    );

    svc_rv_run_ctrl #(
        .RST_CYCLES(1), .TIMEOUT_CYCLES(15), .CNT_W(4), .AUTO_START(1)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_sat), .ebreak(ebreak_sat),
        .cpu_rst_n(cpu_rst_n_sat), .running(running_sat), .done(done_sat),
        .timed_out(timed_out_sat), .cycles(cycles_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_hold_then_run(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_hold_rst"}, 32'(cpu_rst_n), 32'd0);
            step();
        end
        check({tag, "_run_rst"}, 32'(cpu_rst_n), 32'd1);
        check({tag, "_run_cyc0"}, 32'(cycles), 32'd0);
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_running",   32'(running),   32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_timed_out", 32'(timed_out), 32'd0);
        check("rst_cycles",    32'(cycles),    32'd0);
        check("rst_ns_cpu",    32'(cpu_rst_n_ns), 32'd0);
        rst_n = 1'b1;

        // Auto-start: 4-cycle hold, then RUN counting 0,1,2...
        expect_hold_then_run("boot");
        check("boot_running", 32'(running), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            check("boot_count", 32'(cycles), 32'(k - 1));
            step();
        end

        // ebreak on the 10th RUN cycle
        ebreak = 1'b1;
        step();
        ebreak = 1'b0;
        check("eb_done",    32'(done),      32'd1);
        check("eb_cpu_rst", 32'(cpu_rst_n), 32'd0);
        check("eb_running", 32'(running),   32'd0);
        check("eb_cycles",  32'(cycles),    32'd10);
        step(3);
        check("eb_cycles_frozen", 32'(cycles), 32'd10);
        check("eb_done_sticky",   32'(done),   32'd1);

        // start in DONE; ebreak held through HOLD is ignored
        start = 1'b1;
        step();
        start  = 1'b0;
        ebreak = 1'b1;
        check("restart_done_clr", 32'(done),   32'd0);
        check("restart_cyc_clr",  32'(cycles), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("restart_hold_rst", 32'(cpu_rst_n), 32'd0);
            step();
        end
        ebreak = 1'b0;
        check("restart_run_rst", 32'(cpu_rst_n), 32'd1);
        check("restart_no_done", 32'(done),      32'd0);

        // start with ebreak in RUN cycle 5: start wins, immediate abort
        step(4);
        check("abort_pre_cycles", 32'(cycles), 32'd4);
        start  = 1'b1;
        ebreak = 1'b1;
        step();
        start  = 1'b0;
        ebreak = 1'b0;
        check("abort_cpu_rst", 32'(cpu_rst_n), 32'd0);
        check("abort_running", 32'(running),   32'd0);
        check("abort_done",    32'(done),      32'd0);
        check("abort_cycles",  32'(cycles),    32'd0);

        // start in HOLD cycle 3 restarts the hold count
        step(2);
        check("hold_mid_rst", 32'(cpu_rst_n), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        expect_hold_then_run("hold_restart");

        // Watchdog: 100 RUN cycles without ebreak
        step(100);
        check("wdt_cycles", 32'(cycles), 32'd100);
`ifdef SVC_RV_RUN_CTRL_WDT_EN
        check("wdt_timed_out", 32'(timed_out), 32'd1);
        check("wdt_cpu_rst",   32'(cpu_rst_n), 32'd0);
        step(5);
        check("wdt_cycles_frozen", 32'(cycles), 32'd100);
`else
        check("nowdt_timed_out", 32'(timed_out), 32'd0);
        check("nowdt_running",   32'(running),   32'd1);
        step(5);
        check("nowdt_cycles_more", 32'(cycles), 32'd105);
`endif

        // ebreak in the cycle the watchdog would fire: DONE wins
        start = 1'b1;
        step();
        start = 1'b0;
        check("edge_restart_timed_out", 32'(timed_out), 32'd0);
        expect_hold_then_run("edge");
        step(99);
        check("edge_pre_cycles", 32'(cycles), 32'd99);
        ebreak = 1'b1;
        step();
        ebreak = 1'b0;
        check("edge_done",      32'(done),      32'd1);
        check("edge_timed_out", 32'(timed_out), 32'd0);
        check("edge_cycles",    32'(cycles),    32'd100);

        // Asynchronous reset mid-run, off the clock edge
        start = 1'b1;
        step();
        start = 1'b0;
        expect_hold_then_run("pre_arst");
        step(3);
        check("pre_arst_cycles", 32'(cycles), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_cpu_rst", 32'(cpu_rst_n), 32'd0);
        check("arst_cycles",  32'(cycles),    32'd0);
        check("arst_running", 32'(running),   32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        expect_hold_then_run("post_arst");

        // AUTO_START=0 instance: idle until start, ebreak ignored in IDLE and HOLD
        check("ns_idle_cpu_rst", 32'(cpu_rst_n_ns), 32'd0);
        check("ns_idle_running", 32'(running_ns),   32'd0);
        check("ns_idle_done",    32'(done_ns),      32'd0);
        start_ns = 1'b1;
        step();
        start_ns = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ns_hold_rst", 32'(cpu_rst_n_ns), 32'd0);
            step();
        end
        ebreak_ns = 1'b0;
        check("ns_run_rst",  32'(cpu_rst_n_ns), 32'd1);
        check("ns_run_done", 32'(done_ns),      32'd0);
        step(2);
        check("ns_run_cycles", 32'(cycles_ns), 32'd2);

        // 4-bit counter saturates (or stops at the 15-cycle watchdog limit)
        step(20);
        check("sat_cycles", 32'(cycles_sat), 32'd15);
`ifdef SVC_RV_RUN_CTRL_WDT_EN
        check("sat_running", 32'(running_sat), 32'd0);
`else
        check("sat_running", 32'(running_sat), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
